dm_arbiter: RTL
===============

// Module: dm_arbiter
// PURPOSE
//  Shares the single-port word-addressed data memory between two requesters.
//  Port 0 is the CPU load/store path; port 1 is a debug/bulk-load bridge.
//  Performs valid/ready request handshake, round-robin grant and address range
//  check, and returns a registered response with rvalid/rready back-pressure.
//  Sits between requesters and DM; DM read data is combinational from mem_addr.
// PARAMETERS
//  DEPTH_WORDS  3072  DM capacity in 32-bit words; word index >= this is out of range
//  AW           12    width of mem_addr (word index), = addr[AW+1:2]
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  mN_valid     in   1   requester N (N=0,1) request valid
//  mN_ready     out  1   request accepted this cycle when mN_valid && mN_ready
//  mN_we        in   1   1=store, 0=load
//  mN_addr      in   32  byte address; bits [1:0] ignored
//  mN_wdata     in   32  store data
//  mN_be        in   4   byte enables for stores (bit i -> byte i)
//  mN_rvalid    out  1   response valid
//  mN_rready    in   1   response consumed when mN_rvalid && mN_rready
//  mN_rdata     out  32  load data; 0 for stores and errors
//  mN_err       out  1   response flags out-of-range address; valid with mN_rvalid
//  mem_we       out  1   DM write strobe (commits at posedge)
//  mem_be       out  4   DM byte enables
//  mem_addr     out  AW  DM word index
//  mem_wdata    out  32  DM write data
//  mem_rdata    in   32  DM combinational read data for mem_addr
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE, all rvalid/ready/err=0, rdata=0,
//    mem_we=0, last_grant=1 so port 0 wins the first contention.
//  - States: IDLE (may accept), RESP (response held for owner).
//  - IDLE: if exactly one mN_valid, grant it; if both, grant ~last_grant.
//    Grant: mN_ready=1 combinationally in the same cycle, mem_* driven from
//    granted port; mem_we = we && in_range && |be. On posedge: store commits,
//    rdata_q <= (load && in_range) ? mem_rdata : 0, err_q <= !in_range,
//    owner <= N, last_grant <= N, state -> RESP.
//  - Latency: response valid exactly 1 cycle after acceptance. Stores also respond
//    (rdata=0) so the requester gets an ack.
//  - RESP: mOwner_rvalid=1, other port rvalid=0, both mN_ready=0.
//    On rvalid && rready: if a request is pending, grant it in the same cycle
//    (back-to-back, 1 access per cycle); else -> IDLE.
//    If rready=0: hold rdata/err stable, no new grant, mem_we=0.
//  - in_range = (addr[31:2] < DEPTH_WORDS); out-of-range: no write, err=1, rdata=0.
//  - Store with be=4'b0000: no write, normal ack, err=0.
//  - Address wrap: none; addr[31:AW+2] nonzero is out of range, not aliased.
//  - A loser's request is held by its requester (valid stays high); granted next
//    arbitration, so with both ports saturated grants alternate 0,1,0,1.
//  - Reset asserted mid-RESP: pending response dropped, no rvalid after release.
//  - mem_we is never 1 outside an accepting cycle; no write on reset.
// STRUCTURE
//  - Shared package dm_pkg: DM_DEPTH_WORDS, DM_AW, state enum {IDLE, RESP},
//    request struct {we, addr, wdata, be}.
//  - Sub-module rr_arb2: 2-way round-robin grant from {req1,req0} and last_grant;
//    one-hot grant, combinational.
//  - Top holds FSM, owner/last_grant regs, response regs, range check, mem mux.
// TESTING
//  1 Port 0 store addr 0x10 wdata 0xDEADBEEF be 4'hF, then load 0x10 ->
//    load rvalid 1 cycle after accept, rdata=0xDEADBEEF, err=0.
//  2 Both ports valid every cycle, rready=1 -> grants 0,1,0,1; one accept per cycle.
//  3 Port 1 load addr 0x3000 (word 3072) -> err=1, rdata=0; store there ->
//    mem_we stays 0, DM unchanged.
//  4 Load response with rready=0 for 3 cycles -> rvalid/rdata stable, no
//    mN_ready, port 1 pending request accepted the cycle rready rises.
//  5 Store be=4'b0011 wdata 0x12345678 over 0xAAAAAAAA -> read 0xAAAA5678;
//    be=0 store -> ack, word unchanged.
//  6 reset low during RESP -> rvalid/ready 0 immediately; after release port 0
//    wins first contention.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   DM_DEPTH_WORDS : DM capacity in 32-bit words
//   DM_AW          : width of the DM word index
//   dm_state_t     : arbiter FSM states
//   dm_req_t       : one requester's request payload
package dm_pkg;

    localparam int unsigned DM_DEPTH_WORDS = 3072;
    localparam int unsigned DM_AW          = 12;
    localparam int unsigned DM_DW          = 32;
    localparam int unsigned DM_BW          = DM_DW / 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } dm_state_t;

    typedef struct packed {
        logic             we;
        logic [DM_DW-1:0] addr;
        logic [DM_DW-1:0] wdata;
        logic [DM_BW-1:0] be;
    } dm_req_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the data memory.
//   m0_* / m1_* : request channel (valid/ready) and response channel (rvalid/rready)
//   mem_*       : single-port DM access; mem_rdata is combinational from mem_addr
//   slave       : arbiter view
//   master      : requester + memory view (testbench / surrounding fabric)
interface dm_arbiter_if
    import dm_pkg::*;
#(
    parameter int unsigned AW = DM_AW
);

    logic             m0_valid;
    logic             m0_ready;
    logic             m0_we;
    logic [DM_DW-1:0] m0_addr;
    logic [DM_DW-1:0] m0_wdata;
    logic [DM_BW-1:0] m0_be;
    logic             m0_rvalid;
    logic             m0_rready;
    logic [DM_DW-1:0] m0_rdata;
    logic             m0_err;

    logic             m1_valid;
    logic             m1_ready;
    logic             m1_we;
    logic [DM_DW-1:0] m1_addr;
    logic [DM_DW-1:0] m1_wdata;
    logic [DM_BW-1:0] m1_be;
    logic             m1_rvalid;
    logic             m1_rready;
    logic [DM_DW-1:0] m1_rdata;
    logic             m1_err;

    logic             mem_we;
    logic [DM_BW-1:0] mem_be;
    logic [AW-1:0]    mem_addr;
    logic [DM_DW-1:0] mem_wdata;
    logic [DM_DW-1:0] mem_rdata;

    modport slave (
        input  m0_valid, m0_we, m0_addr, m0_wdata, m0_be, m0_rready,
        output m0_ready, m0_rvalid, m0_rdata, m0_err,
        input  m1_valid, m1_we, m1_addr, m1_wdata, m1_be, m1_rready,
        output m1_ready, m1_rvalid, m1_rdata, m1_err,
        output mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_valid, m0_we, m0_addr, m0_wdata, m0_be, m0_rready,
        input  m0_ready, m0_rvalid, m0_rdata, m0_err,
        output m1_valid, m1_we, m1_addr, m1_wdata, m1_be, m1_rready,
        input  m1_ready, m1_rvalid, m1_rdata, m1_err,
        input  mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   req        : {req1, req0}
//   last_grant : index of the most recent winner
//   gnt_c      : one-hot grant (zero when nothing requested)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt_c
);

    // On contention the port that did not win last time goes first.
    always_comb begin
        gnt_c = req;
        if (&req) begin
            gnt_c = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates two requesters onto the single-port data memory.
// Accepts one request per cycle, round-robin on contention, range-checks the
// word index and returns a registered response one cycle after acceptance.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : requester channels and DM port (slave view)
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int unsigned AW          = DM_AW
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);

    dm_state_t        state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [DM_DW-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    dm_req_t          req0, req1, sel;
    logic [1:0]       req_v;
    logic [1:0]       gnt;
    logic [1:0]       gnt_ok;
    logic             resp_done;
    logic             can_accept;
    logic             accept;
    logic             in_range;
    logic             unused_addr_lsb;

    assign req0  = {bus.m0_we, bus.m0_addr, bus.m0_wdata, bus.m0_be};
    assign req1  = {bus.m1_we, bus.m1_addr, bus.m1_wdata, bus.m1_be};
    assign req_v = {bus.m1_valid, bus.m0_valid};

    rr_arb2 u_rr_arb2 (
        .req        (req_v),
        .last_grant (last_q),
        .gnt_c      (gnt)
    );

    // Acceptance window: idle, or the held response is being consumed this cycle.
    // Reset also closes the window so nothing is granted or written while asserted.
    always_comb begin
        resp_done  = (state_q == RESP) && (owner_q ? bus.m1_rready : bus.m0_rready);
        can_accept = reset && ((state_q == IDLE) || resp_done);
        gnt_ok     = can_accept ? gnt : 2'b00;
        accept     = |gnt_ok;
        sel        = gnt[1] ? req1 : req0;
        // Full upper address compared, so high bits never alias into the DM.
        in_range   = DM_DW'({2'b00, sel.addr[DM_DW-1:2]}) < DM_DW'(DEPTH_WORDS);
    end

    assign unused_addr_lsb = ^sel.addr[1:0];

    // Memory port and request-ready, driven from the granted requester.
    always_comb begin
        bus.m0_ready  = gnt_ok[0];
        bus.m1_ready  = gnt_ok[1];
        bus.mem_we    = accept && sel.we && in_range && (|sel.be);
        bus.mem_be    = sel.be;
        bus.mem_addr  = sel.addr[AW+1:2];
        bus.mem_wdata = sel.wdata;
    end

    // Next-state and response capture.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: state_d = IDLE;
            RESP: if (resp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = RESP;
            owner_d = gnt[1];
            last_d  = gnt[1];
            rdata_d = (!sel.we && in_range) ? bus.mem_rdata : '0;
            err_d   = !in_range;
        end
    end

    // State and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Response outputs: only the owner sees rvalid; data/err read as zero otherwise.
    always_comb begin
        bus.m0_rvalid = (state_q == RESP) && !owner_q;
        bus.m1_rvalid = (state_q == RESP) && owner_q;
        bus.m0_rdata  = bus.m0_rvalid ? rdata_q : '0;
        bus.m1_rdata  = bus.m1_rvalid ? rdata_q : '0;
        bus.m0_err    = bus.m0_rvalid && err_q;
        bus.m1_err    = bus.m1_rvalid && err_q;
    end

endmodule
